pipeline_hazard_ctrl: RTL

//   Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB). Generates stall, flush and

---
 rtl/pipe_ctrl_pkg.sv | 8 +
 rtl/forwarding_unit.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, forwarding select codes and NOP encoding for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: combinational EX operand bypass select.
//   in : ex_rs1/ex_rs2 (EX source regs), ex_mem_regw/ex_mem_rd, mem_wb_regw/mem_wb_rd (producers)
//   out: forward_a/forward_b (FWD_RF, FWD_EXMEM or FWD_MEMWB; the younger EX_MEM result wins)
module forwarding_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic       ex_mem_regw,
  input  logic [4:0] ex_mem_rd,
  input  logic       mem_wb_regw,
  input  logic [4:0] mem_wb_rd,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);
  logic ex_ok, wb_ok;
  assign ex_ok = ex_mem_regw && ex_mem_rd != 5'd0;
  assign wb_ok = mem_wb_regw && mem_wb_rd != 5'd0;
  always_comb begin
    forward_a = (ex_ok && ex_mem_rd == ex_rs1) ? FWD_EXMEM : (wb_ok && mem_wb_rd == ex_rs1) ? FWD_MEMWB : FWD_RF;
    forward_b = (ex_ok && ex_mem_rd == ex_rs2) ? FWD_EXMEM : (wb_ok && mem_wb_rd == ex_rs2) ? FWD_MEMWB : FWD_RF;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward sequencer for the 5-stage pipeline.
//   in : reset (sync, active-low), ID/EX/MEM/WB register ids and control bits, dmem_req/dmem_ready
//   out: PC_Write, IF_ID_Write, IF_ID/ID_EX/EX_MEM flushes, MEM_Hold, ForwardA/B,
//        mem_err (sticky wait timeout), stall_cnt/flush_cnt (saturating)
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_RegRs1,
  input  logic [4:0]       IF_ID_RegRs2,
  input  logic             IF_ID_UsesRs2,
  input  logic [4:0]       ID_EX_RegRs1,
  input  logic [4:0]       ID_EX_RegRs2,
  input  logic [4:0]       ID_EX_RegRd,
  input  logic             ID_EX_MemR,
  input  logic             EX_MEM_RegW,
  input  logic [4:0]       EX_MEM_RegRd,
  input  logic             EX_MEM_BrTaken,
  input  logic             MEM_WB_RegW,
  input  logic [4:0]       MEM_WB_RegRd,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             MEM_Hold,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             mem_miss, load_use, br_flush;
  assign mem_miss = dmem_req && !dmem_ready;
  assign load_use = ID_EX_MemR && ID_EX_RegRd != 5'd0 &&
                    (ID_EX_RegRd == IF_ID_RegRs1 || (IF_ID_UsesRs2 && ID_EX_RegRd == IF_ID_RegRs2));
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      timer_q     <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  // The ready cycle is still a held cycle; release happens on the following edge.
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    mem_err_d = mem_err_q;
    if (state_q == RUN) state_d = mem_miss ? MEM_WAIT : RUN;
    else if (dmem_ready) state_d = RUN;
    else if (timer_q == TW'(MEM_TIMEOUT - 1)) begin
      state_d   = RUN;
      mem_err_d = 1'b1;
    end else timer_d = timer_q + TW'(1);
  end
  // Memory hold outranks a taken branch, which outranks a load-use stall.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    MEM_Hold     = 1'b0;
    br_flush     = 1'b0;
    if (state_q == MEM_WAIT || mem_miss) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      MEM_Hold    = 1'b1;
    end else if (EX_MEM_BrTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
      br_flush     = 1'b1;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end
  always_comb begin
    stall_cnt_d = (!PC_Write && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (br_flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  forwarding_unit u_fwd (
    .ex_rs1     (ID_EX_RegRs1),
    .ex_rs2     (ID_EX_RegRs2),
    .ex_mem_regw(EX_MEM_RegW),
    .ex_mem_rd  (EX_MEM_RegRd),
    .mem_wb_regw(MEM_WB_RegW),
    .mem_wb_rd  (MEM_WB_RegRd),
    .forward_a  (ForwardA),
    .forward_b  (ForwardB)
  );
endmodule
